// File: rtl/aes_key_sched_pkg.sv
// Shared constants, key-length encodings and GF(2^8) helpers for the AES key schedule.
// InvMixColumns helper is compiled only with AES_KEY_SCHED_INV_EN.
package aes_key_sched_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned KEY_W       = 256;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned STORE_DEPTH = 64;
  localparam int unsigned WORDS_128   = 44;
  localparam int unsigned WORDS_192   = 52;
  localparam int unsigned WORDS_256   = 60;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_GEN  = 2'b10
  } state_e;

  function automatic logic [3:0] nk_of(key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] words_of(key_len_e kl);
    case (kl)
      KL_192:  return IDX_W'(WORDS_192);
      KL_256:  return IDX_W'(WORDS_256);
      default: return IDX_W'(WORDS_128);
    endcase
  endfunction

  function automatic logic [7:0] rcon_of(logic [3:0] j);
    case (j)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform
  function automatic logic [7:0] sbox(logic [7:0] a);
    logic [7:0] s;
    logic [7:0] inv;
    s   = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s   = gf_mul(s, s);
      inv = gf_mul(inv, s);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD_W-1:0] sub_word(logic [WORD_W-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

`ifdef AES_KEY_SCHED_INV_EN
  function automatic logic [WORD_W-1:0] inv_mix_word(logic [WORD_W-1:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
`endif

endpackage

// File: rtl/aes_key_word_gen.sv
// RotWord/SubWord/Rcon temp-word generator with SBOX_LATENCY pipeline stages.
// Inputs must stay stable for SBOX_LATENCY enabled cycles before temp_c is used.
module aes_key_word_gen
  import aes_key_sched_pkg::*;
#(
  parameter int unsigned SBOX_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WORD_W-1:0] w_in,
  input  logic              rot,
  input  logic [7:0]        rcon,
  output logic [WORD_W-1:0] temp_c
);

  logic [WORD_W-1:0] sub_in;
  logic [WORD_W-1:0] sub_out;

  assign sub_in = sub_word(rot ? {w_in[23:0], w_in[31:24]} : w_in);

  if (SBOX_LATENCY == 0) begin : g_comb
    assign sub_out = sub_in;
  end else begin : g_pipe
    logic [WORD_W-1:0] stage_q [SBOX_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(SBOX_LATENCY); i++) stage_q[i] <= '0;
      end else if (en) begin
        stage_q[0] <= sub_in;
        for (int i = 1; i < int'(SBOX_LATENCY); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign sub_out = stage_q[SBOX_LATENCY-1];
  end

  // Rcon only applies on RotWord steps
  assign temp_c = sub_out ^ {(rot ? rcon : 8'h00), 24'h000000};

endmodule

// File: rtl/aes_key_sched.sv
// AES-128/192/256 key expansion with round-key storage and combinational read port.
// Optional build macro AES_KEY_SCHED_INV_EN adds rk_rd_inv (InvMixColumns view).
module aes_key_sched
  import aes_key_sched_pkg::*;
#(
  parameter int unsigned SBOX_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sys_en,
  input  logic               start,
  input  logic [1:0]         key_len,
  input  logic [KEY_W-1:0]   key,
  input  logic [3:0]         rk_rd_idx,
`ifdef AES_KEY_SCHED_INV_EN
  input  logic               rk_rd_inv,
`endif
  output logic [BLOCK_W-1:0] rk_rd_data,
  output logic               busy,
  output logic               done,
  output logic               keys_valid,
  output logic               err
);

  state_e            state_q, state_d;
  key_len_e          kl_q;
  logic [KEY_W-1:0]  key_q;
  logic [WORD_W-1:0] words_q [STORE_DEPTH];
  logic [IDX_W-1:0]  gen_i_q;
  logic [2:0]        pos_q;
  logic [3:0]        rnd_q;
  logic [1:0]        wait_q;

  logic              busy_d, done_d, err_d, kv_d;
  logic [3:0]        nk_c, nr_c;
  logic              need_sub_c, word_wr_c, last_c, accept_c;
  logic [WORD_W-1:0] prev_c, temp_c, new_word_c;

  assign nk_c       = nk_of(kl_q);
  assign nr_c       = nr_of(kl_q);
  assign need_sub_c = (pos_q == 3'd0) || ((kl_q == KL_256) && (pos_q == 3'd4));
  assign word_wr_c  = sys_en && (state_q == ST_GEN) &&
                      (!need_sub_c || (wait_q == 2'(SBOX_LATENCY)));
  assign last_c     = (gen_i_q == (words_of(kl_q) - IDX_W'(1)));
  assign accept_c   = sys_en && (state_q == ST_IDLE) && start &&
                      (key_len_e'(key_len) != KL_BAD);
  assign prev_c     = words_q[gen_i_q - IDX_W'(1)];
  assign new_word_c = words_q[gen_i_q - IDX_W'(nk_c)] ^ (need_sub_c ? temp_c : prev_c);

  aes_key_word_gen #(
    .SBOX_LATENCY(SBOX_LATENCY)
  ) u_word_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (sys_en),
    .w_in   (prev_c),
    .rot    (pos_q == 3'd0),
    .rcon   (rcon_of(rnd_q)),
    .temp_c (temp_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (sys_en) begin
      case (state_q)
        ST_IDLE: if (accept_c) state_d = ST_LOAD;
        ST_LOAD: state_d = ST_GEN;
        ST_GEN:  if (word_wr_c && last_c) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output next values; pulses are one cycle regardless of sys_en
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = word_wr_c && last_c;
    err_d  = sys_en && (state_q == ST_IDLE) && start && (key_len_e'(key_len) == KL_BAD);
    kv_d   = keys_valid;
    if (accept_c) kv_d = 1'b0;
    if (done_d)   kv_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      keys_valid <= kv_d;
    end
  end

  // Key latch, word storage and generation counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kl_q    <= KL_128;
      key_q   <= '0;
      gen_i_q <= '0;
      pos_q   <= '0;
      rnd_q   <= '0;
      wait_q  <= '0;
      for (int k = 0; k < int'(STORE_DEPTH); k++) words_q[k] <= '0;
    end else if (sys_en) begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            kl_q  <= key_len_e'(key_len);
            key_q <= key;
          end
        end
        ST_LOAD: begin
          for (int k = 0; k < 8; k++) begin
            if (4'(k) < nk_c) words_q[k] <= key_q[KEY_W-1-32*k -: 32];
          end
          gen_i_q <= IDX_W'(nk_c);
          pos_q   <= '0;
          rnd_q   <= 4'd1;
          wait_q  <= '0;
        end
        ST_GEN: begin
          if (word_wr_c) begin
            words_q[gen_i_q] <= new_word_c;
            gen_i_q          <= gen_i_q + IDX_W'(1);
            pos_q            <= (pos_q == 3'(nk_c - 4'd1)) ? 3'd0 : pos_q + 3'd1;
            if (pos_q == 3'd0) rnd_q <= rnd_q + 4'd1;
            wait_q           <= '0;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-key read port; indices beyond Nr read zero
  logic [IDX_W-1:0]  rd_base;
  logic [WORD_W-1:0] rd_word;

  always_comb begin
    rd_base    = {rk_rd_idx, 2'b00};
    rd_word    = '0;
    rk_rd_data = '0;
    if (rk_rd_idx <= nr_c) begin
      for (int k = 0; k < 4; k++) begin
        rd_word = words_q[rd_base + IDX_W'(k)];
`ifdef AES_KEY_SCHED_INV_EN
        if (rk_rd_inv && (rk_rd_idx != 4'd0) && (rk_rd_idx != nr_c)) rd_word = inv_mix_word(rd_word);
`endif
        rk_rd_data[BLOCK_W-1-32*k -: 32] = rd_word;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched (SBOX_LATENCY=1) using FIPS-197 key expansion vectors.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sys_en;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [3:0]   rk_rd_idx;
`ifdef AES_KEY_SCHED_INV_EN
  logic         rk_rd_inv;
`endif
  logic [127:0] rk_rd_data;
  logic         busy, done, keys_valid, err;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [255:0] K128   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdef0123456789abcdef};
  localparam logic [127:0] R0_128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_128 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K192   = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
  localparam logic [127:0] R0_192 = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R0_256 = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_sched #(.SBOX_LATENCY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys_en     (sys_en),
    .start      (start),
    .key_len    (key_len),
    .key        (key),
    .rk_rd_idx  (rk_rd_idx),
`ifdef AES_KEY_SCHED_INV_EN
    .rk_rd_inv  (rk_rd_inv),
`endif
    .rk_rd_data (rk_rd_data),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Stimulus only: issue a start, scramble key inputs afterwards, return done latency (-1 on timeout)
  task automatic run_start(input logic [1:0] kl, input logic [255:0] k, output int cycles);
    @(posedge clk); #1;
    key_len = kl; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_len = 2'b10; key = ~k;
    cycles = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (done) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] d);
    rk_rd_idx = 4'(idx);
    #1;
    d = rk_rd_data;
  endtask

  task automatic test_reset;
    logic [127:0] d;
    rst_n = 1'b0; sys_en = 1'b1; start = 1'b0; key_len = 2'b00; key = '0; rk_rd_idx = '0;
`ifdef AES_KEY_SCHED_INV_EN
    rk_rd_inv = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, keys_valid, err} !== 4'b0000) begin
      n_fails++; $display("FAIL reset_outputs: got %b expected 0000", {busy, done, keys_valid, err});
    end
    read_rk(0, d);
    n_checks++;
    if (d !== 128'h0) begin n_fails++; $display("FAIL reset_rk0: got %h expected 0", d); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, keys_valid} !== 3'b000) begin
      n_fails++; $display("FAIL reset_first_edge: got %b expected 000", {busy, done, keys_valid});
    end
  endtask

  task automatic test_aes128;
    int cyc;
    logic [127:0] d;
    run_start(2'b00, K128, cyc);
    n_checks++;
    if (cyc !== 51) begin n_fails++; $display("FAIL aes128_latency: got %0d expected 51", cyc); end
    n_checks++;
    if ({busy, keys_valid} !== 2'b01) begin
      n_fails++; $display("FAIL aes128_flags: got busy/kv %b expected 01", {busy, keys_valid});
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fails++; $display("FAIL aes128_done_pulse: got %b expected 0", done); end
    read_rk(0, d);
    n_checks++;
    if (d !== R0_128) begin n_fails++; $display("FAIL aes128_rk0: got %h expected %h", d, R0_128); end
    read_rk(1, d);
    n_checks++;
    if (d !== R1_128) begin n_fails++; $display("FAIL aes128_rk1: got %h expected %h", d, R1_128); end
    read_rk(10, d);
    n_checks++;
    if (d !== R10_128) begin n_fails++; $display("FAIL aes128_rk10: got %h expected %h", d, R10_128); end
    read_rk(11, d);
    n_checks++;
    if (d !== 128'h0) begin n_fails++; $display("FAIL aes128_rk11_zero: got %h expected 0", d); end
  endtask

  task automatic test_illegal_len;
    logic [127:0] d;
    @(posedge clk); #1;
    key_len = 2'b11; key = K256; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({err, busy, keys_valid} !== 3'b101) begin
      n_fails++; $display("FAIL illegal_err: got err/busy/kv %b expected 101", {err, busy, keys_valid});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({err, busy, keys_valid} !== 3'b001) begin
      n_fails++; $display("FAIL illegal_after: got err/busy/kv %b expected 001", {err, busy, keys_valid});
    end
    read_rk(10, d);
    n_checks++;
    if (d !== R10_128) begin n_fails++; $display("FAIL illegal_rk10: got %h expected %h", d, R10_128); end
  endtask

  task automatic test_aes192;
    int cyc;
    logic [127:0] d;
    run_start(2'b01, K192, cyc);
    n_checks++;
    if (cyc !== 55) begin n_fails++; $display("FAIL aes192_latency: got %0d expected 55", cyc); end
    read_rk(0, d);
    n_checks++;
    if (d !== R0_192) begin n_fails++; $display("FAIL aes192_rk0: got %h expected %h", d, R0_192); end
    read_rk(12, d);
    n_checks++;
    if (d !== R12_192) begin n_fails++; $display("FAIL aes192_rk12: got %h expected %h", d, R12_192); end
    read_rk(13, d);
    n_checks++;
    if (d !== 128'h0) begin n_fails++; $display("FAIL aes192_rk13_zero: got %h expected 0", d); end
  endtask

  task automatic test_aes256;
    int cyc;
    logic [127:0] d;
    run_start(2'b10, K256, cyc);
    n_checks++;
    if (cyc !== 66) begin n_fails++; $display("FAIL aes256_latency: got %0d expected 66", cyc); end
    read_rk(0, d);
    n_checks++;
    if (d !== R0_256) begin n_fails++; $display("FAIL aes256_rk0: got %h expected %h", d, R0_256); end
    read_rk(14, d);
    n_checks++;
    if (d !== R14_256) begin n_fails++; $display("FAIL aes256_rk14: got %h expected %h", d, R14_256); end
    read_rk(15, d);
    n_checks++;
    if (d !== 128'h0) begin n_fails++; $display("FAIL aes256_rk15_zero: got %h expected 0", d); end
  endtask

  task automatic test_reset_mid_gen;
    int cyc;
    logic [127:0] d;
    @(posedge clk); #1;
    key_len = 2'b00; key = K128; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, keys_valid} !== 2'b10) begin
      n_fails++; $display("FAIL midgen_flags: got busy/kv %b expected 10", {busy, keys_valid});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, keys_valid, err} !== 4'b0000) begin
      n_fails++; $display("FAIL midreset_outputs: got %b expected 0000", {busy, done, keys_valid, err});
    end
    read_rk(0, d);
    n_checks++;
    if (d !== 128'h0) begin n_fails++; $display("FAIL midreset_rk0: got %h expected 0", d); end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, keys_valid, err} !== 4'b0000) begin
      n_fails++; $display("FAIL midreset_held: got %b expected 0000", {busy, done, keys_valid, err});
    end
    rst_n = 1'b1;
    run_start(2'b00, K128, cyc);
    n_checks++;
    if (cyc !== 51) begin n_fails++; $display("FAIL rerun_latency: got %0d expected 51", cyc); end
    read_rk(10, d);
    n_checks++;
    if (d !== R10_128) begin n_fails++; $display("FAIL rerun_rk10: got %h expected %h", d, R10_128); end
  endtask

  task automatic test_stall_back_to_back;
    int cyc;
    int dones;
    int errs;
    logic [127:0] d;
    @(posedge clk); #1;
    key_len = 2'b00; key = K128; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = -1; dones = 0; errs = 0;
    for (int c = 1; c <= 90; c++) begin
      sys_en  = (c >= 10 && c < 40) ? ((c % 2) == 1) : 1'b1;
      start   = (c == 5 || c == 6);
      key_len = start ? 2'b10 : 2'b00;
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (cyc < 0) cyc = c;
      end
      if (err) errs++;
    end
    start = 1'b0; sys_en = 1'b1;
    n_checks++;
    if (cyc !== 66) begin n_fails++; $display("FAIL stall_latency: got %0d expected 66", cyc); end
    n_checks++;
    if (dones !== 1) begin n_fails++; $display("FAIL stall_done_count: got %0d expected 1", dones); end
    n_checks++;
    if (errs !== 0) begin n_fails++; $display("FAIL stall_err_count: got %0d expected 0", errs); end
    n_checks++;
    if ({busy, keys_valid} !== 2'b01) begin
      n_fails++; $display("FAIL stall_flags: got busy/kv %b expected 01", {busy, keys_valid});
    end
    read_rk(10, d);
    n_checks++;
    if (d !== R10_128) begin n_fails++; $display("FAIL stall_rk10: got %h expected %h", d, R10_128); end
    read_rk(11, d);
    n_checks++;
    if (d !== 128'h0) begin n_fails++; $display("FAIL stall_rk11_zero: got %h expected 0", d); end
  endtask

  initial begin
    test_reset;
    test_aes128;
    test_illegal_len;
    test_aes192;
    test_aes256;
    test_reset_mid_gen;
    test_stall_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
